// File: rtl/stopwatch_time_counter.sv
// MM:SS BCD stopwatch core. The divided tick/adjust square waves are synchronized and
// edge-detected in the clk domain, then drive a pausable, clearable, per-field-adjustable counter.
module stopwatch_time_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int SEC_LIMIT   = 59,
  parameter int MIN_LIMIT   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_clk,
  input  logic       adj_clk,
  input  logic       pause,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       rollover,
  output logic       running
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);
  localparam logic [7:0] SEC_LIM_BCD = {4'(SEC_LIMIT / 10), 4'(SEC_LIMIT % 10)};
  localparam logic [7:0] MIN_LIM_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};

  logic [SYNC_STAGES-1:0] r_tick_sync, r_adj_sync;
  logic                   r_tick_prev, r_adj_prev;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic [7:0]             r_sec, r_min;
  logic                   r_rollover, r_running;

  logic       w_armed, w_tick_lvl, w_adj_lvl, w_rise_tick, w_rise_adj;
  logic       w_sec_at_lim, w_min_at_lim;
  logic [7:0] w_sec_next, w_min_next;

  // Two-digit BCD increment that wraps to 00 once the limit is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_armed      = (r_arm_cnt == ARM_W'(ARM_MAX));
  assign w_tick_lvl   = r_tick_sync[SYNC_STAGES-1];
  assign w_adj_lvl    = r_adj_sync[SYNC_STAGES-1];
  assign w_rise_tick  = w_tick_lvl & ~r_tick_prev & w_armed;
  assign w_rise_adj   = w_adj_lvl & ~r_adj_prev & w_armed;
  assign w_sec_at_lim = (r_sec == SEC_LIM_BCD);
  assign w_min_at_lim = (r_min == MIN_LIM_BCD);
  assign w_sec_next   = bcd_inc(r_sec, SEC_LIM_BCD);
  assign w_min_next   = bcd_inc(r_min, MIN_LIM_BCD);

  // Edge history keeps tracking the level while masked, so a level already high
  // when arming completes is never seen as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_sync <= '0;
      r_adj_sync  <= '0;
      r_tick_prev <= 1'b0;
      r_adj_prev  <= 1'b0;
      r_arm_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let the shift chain read old stage values.
      r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_clk};
      r_adj_sync  <= {r_adj_sync[SYNC_STAGES-2:0], adj_clk};
      r_tick_prev <= w_tick_lvl;
      r_adj_prev  <= w_adj_lvl;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  // clr beats pause beats the mode action; edges seen while paused are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_rollover <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      r_running  <= ~pause & ~adj;
      if (clr) begin
        r_sec <= 8'h00;
        r_min <= 8'h00;
      end else if (!pause) begin
        if (!adj && w_rise_tick) begin
          r_sec <= w_sec_next;
          if (w_sec_at_lim) begin
            r_min <= w_min_next;
            if (w_min_at_lim) r_rollover <= 1'b1;
          end
        end else if (adj && w_rise_adj) begin
          if (sel) r_min <= w_min_next;
          else     r_sec <= w_sec_next;
        end
      end
    end
  end

  assign min_tens = r_min[7:4];
  assign min_ones = r_min[3:0];
  assign sec_tens = r_sec[7:4];
  assign sec_ones = r_sec[3:0];
  assign rollover = r_rollover;
  assign running  = r_running;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: arming, latency, BCD carry, wrap/rollover,
// adjust fields, pause, clear and asynchronous reset.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic rst, tick_clk, adj_clk, pause, clr, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic rollover, running;
  logic [15:0] w_time;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_time_counter #(.SYNC_STAGES(2), .SEC_LIMIT(59), .MIN_LIMIT(59)) dut (
    .clk(clk), .rst(rst), .tick_clk(tick_clk), .adj_clk(adj_clk),
    .pause(pause), .clr(clr), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .rollover(rollover), .running(running)
  );

  assign w_time = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each pulse is 4 cycles high, 4 low: one edge, fully applied when the task returns.
  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_clk = 1'b1; cyc(4);
      tick_clk = 1'b0; cyc(4);
    end
  endtask

  task automatic pulse_adj(input int n);
    for (int i = 0; i < n; i++) begin
      adj_clk = 1'b1; cyc(4);
      adj_clk = 1'b0; cyc(4);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick_clk = 1'b1; adj_clk = 1'b0;
    pause = 1'b0; clr = 1'b0; adj = 1'b0; sel = 1'b0;
    cyc(3);
    check("reset_time", w_time, 16'h0000);
    check("reset_rollover", {15'b0, rollover}, 16'd0);
    check("reset_running", {15'b0, running}, 16'd0);

    // Input already high at release must not count.
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("armhold_time", w_time, 16'h0000);
      check("armhold_rollover", {15'b0, rollover}, 16'd0);
    end
    tick_clk = 1'b0; cyc(4);
    check("running_normal", {15'b0, running}, 16'd1);

    // First edge latency: update lands on the 3rd clk edge after the rise.
    tick_clk = 1'b1; cyc(2);
    check("latency_early", w_time, 16'h0000);
    cyc(1);
    check("latency_exact", w_time, 16'h0001);
    cyc(1); tick_clk = 1'b0; cyc(4);
    pulse_tick(9);
    check("normal_10", w_time, 16'h0010);

    // Adjust seconds: 10 -> 59, then wrap with no carry into minutes.
    adj = 1'b1; sel = 1'b0; cyc(2);
    check("running_adj", {15'b0, running}, 16'd0);
    pulse_adj(49);
    check("adj_sec_59", w_time, 16'h0059);
    pulse_adj(1);
    check("adj_sec_wrap", w_time, 16'h0000);
    sel = 1'b1; pulse_adj(3);
    check("adj_min_3", w_time, 16'h0300);
    pulse_tick(2);
    check("adj_ignores_tick", w_time, 16'h0300);
    check("adj_no_rollover", {15'b0, rollover}, 16'd0);

    // Preload 59:58.
    pulse_adj(56);
    check("adj_min_59", w_time, 16'h5900);
    sel = 1'b0; pulse_adj(58);
    check("preload", w_time, 16'h5958);
    adj = 1'b0; cyc(2);
    pulse_adj(2);
    check("normal_ignores_adj", w_time, 16'h5958);
    pulse_tick(1);
    check("normal_5959", w_time, 16'h5959);

    tick_clk = 1'b1; cyc(2);
    check("wrap_before", w_time, 16'h5959);
    check("wrap_before_ro", {15'b0, rollover}, 16'd0);
    cyc(1);
    check("wrap_time", w_time, 16'h0000);
    check("wrap_rollover", {15'b0, rollover}, 16'd1);
    cyc(1);
    check("wrap_rollover_1cyc", {15'b0, rollover}, 16'd0);
    tick_clk = 1'b0; cyc(4);

    // Pause: edges discarded, no catch-up.
    pulse_tick(3);
    check("pre_pause", w_time, 16'h0003);
    pause = 1'b1; cyc(1);
    pulse_tick(5);
    check("paused_hold", w_time, 16'h0003);
    check("running_paused", {15'b0, running}, 16'd0);
    pause = 1'b0; cyc(8);
    check("no_catchup", w_time, 16'h0003);
    pulse_tick(1);
    check("after_pause", w_time, 16'h0004);

    // Clear wins over a simultaneous tick edge.
    tick_clk = 1'b1; cyc(2);
    clr = 1'b1; cyc(1);
    check("clr_with_tick", w_time, 16'h0000);
    check("clr_no_rollover", {15'b0, rollover}, 16'd0);
    clr = 1'b0; cyc(1); tick_clk = 1'b0; cyc(4);
    check("clr_stays", w_time, 16'h0000);

    // Load 12:34, then async reset between clk edges.
    adj = 1'b1; sel = 1'b1; pulse_adj(12);
    sel = 1'b0; pulse_adj(34);
    adj = 1'b0; cyc(2);
    check("load_1234", w_time, 16'h1234);
    #2 rst = 1'b1;
    #1;
    check("async_rst_time", w_time, 16'h0000);
    check("async_rst_running", {15'b0, running}, 16'd0);
    cyc(2); rst = 1'b0; cyc(6);
    check("post_rst_time", w_time, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
